// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (BF16 by default) with RNE rounding,
// special-value handling, valid/ready back-pressure, tag pass-through and sticky flags.
module fp_mul_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 7,
   parameter int unsigned TAG_W = 4,
   localparam int unsigned W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic [4:0]       out_flags,
   input  logic             clr_flags,
   output logic [4:0]       sticky_flags
);

   localparam int unsigned EW2 = EXP_W + 2;
   localparam int unsigned SW  = MAN_W + 1;
   localparam int unsigned PW  = 2 * SW;
   localparam logic signed [EW2-1:0] BIAS_S = EW2'(2**(EXP_W-1) - 1);
   localparam logic signed [EW2-1:0] E_MAX  = EW2'(2**EXP_W - 1);
   localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
   localparam logic signed [EW2-1:0] E_ZERO = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic advance;

   // stage 1 registers
   logic                  s1_valid;
   logic [TAG_W-1:0]      s1_tag;
   logic                  s1_special;
   logic [W-1:0]          s1_res;
   logic [4:0]            s1_flags;
   logic                  s1_sign;
   logic signed [EW2-1:0] s1_exp;
   logic [SW-1:0]         s1_sig_a;
   logic [SW-1:0]         s1_sig_b;

   // stage 2 registers
   logic                  s2_valid;
   logic [TAG_W-1:0]      s2_tag;
   logic                  s2_special;
   logic [W-1:0]          s2_res;
   logic [4:0]            s2_flags;
   logic                  s2_sign;
   logic signed [EW2-1:0] s2_exp;
   logic [PW-1:0]         s2_prod;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // S1: classify operands and select special results
   logic                  sign_a, sign_b, sign_r;
   logic [EXP_W-1:0]      exp_a, exp_b;
   logic [MAN_W-1:0]      man_a, man_b;
   logic                  zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic                  sp_n;
   logic [W-1:0]          sp_res_n;
   logic [4:0]            sp_flags_n;
   logic signed [EW2-1:0] e_sum;

   assign {sign_a, exp_a, man_a} = in_a;
   assign {sign_b, exp_b, man_b} = in_b;
   assign sign_r = sign_a ^ sign_b;
   assign zero_a = (exp_a == '0);
   assign zero_b = (exp_b == '0);
   assign inf_a  = (exp_a == '1) && (man_a == '0);
   assign inf_b  = (exp_b == '1) && (man_b == '0);
   assign nan_a  = (exp_a == '1) && (man_a != '0);
   assign nan_b  = (exp_b == '1) && (man_b != '0);
   assign e_sum  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

   always_comb begin
      sp_n       = 1'b1;
      sp_res_n   = '0;
      sp_flags_n = '0;
      if (nan_a || nan_b) begin
         sp_res_n   = QNAN;
         sp_flags_n = 5'b10000;
      end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
         sp_res_n   = QNAN;
         sp_flags_n = 5'b10000;
      end else if (inf_a || inf_b) begin
         sp_res_n   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (zero_a || zero_b) begin
         sp_res_n   = {sign_r, {(W-1){1'b0}}};
         sp_flags_n = 5'b00001;
      end else begin
         sp_n       = 1'b0;
      end
   end

   // S3: normalise, round to nearest even, range check, pack
   logic [PW-2:0]         p_norm;
   logic signed [EW2-1:0] e_norm, e_rnd;
   logic [MAN_W-1:0]      man_t;
   logic [MAN_W:0]        man_r;
   logic                  guard_b, sticky_b, rnd_up, inexact;
   logic [W-1:0]          res_n;
   logic [4:0]            flags_n;

   always_comb begin
      p_norm   = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
      e_norm   = s2_prod[PW-1] ? (s2_exp + E_ONE) : s2_exp;
      man_t    = p_norm[PW-2 -: MAN_W];
      guard_b  = p_norm[PW-2-MAN_W];
      sticky_b = |p_norm[PW-3-MAN_W:0];
      rnd_up   = guard_b & (sticky_b | man_t[0]);
      man_r    = {1'b0, man_t} + (MAN_W+1)'(rnd_up);
      // carry-out leaves the low mantissa bits at zero already
      e_rnd    = man_r[MAN_W] ? (e_norm + E_ONE) : e_norm;
      inexact  = guard_b | sticky_b;
      res_n    = {s2_sign, e_rnd[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags_n  = {3'b000, inexact, 1'b0};
      if (s2_special) begin
         res_n   = s2_res;
         flags_n = s2_flags;
      end else if (e_rnd >= E_MAX) begin
         res_n   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_n = 5'b01010;
      end else if (e_rnd <= E_ZERO) begin
         res_n   = {s2_sign, {(W-1){1'b0}}};
         flags_n = 5'b00111;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_tag     <= '0;
         s1_special <= 1'b0;
         s1_res     <= '0;
         s1_flags   <= '0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_sig_a   <= '0;
         s1_sig_b   <= '0;
         s2_valid   <= 1'b0;
         s2_tag     <= '0;
         s2_special <= 1'b0;
         s2_res     <= '0;
         s2_flags   <= '0;
         s2_sign    <= 1'b0;
         s2_exp     <= '0;
         s2_prod    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tag    <= '0;
         out_flags  <= '0;
      end else if (advance) begin
         s1_valid   <= in_valid;
         s1_tag     <= in_tag;
         s1_special <= sp_n;
         s1_res     <= sp_res_n;
         s1_flags   <= sp_flags_n;
         s1_sign    <= sign_r;
         s1_exp     <= e_sum;
         s1_sig_a   <= {1'b1, man_a};
         s1_sig_b   <= {1'b1, man_b};
         s2_valid   <= s1_valid;
         s2_tag     <= s1_tag;
         s2_special <= s1_special;
         s2_res     <= s1_res;
         s2_flags   <= s1_flags;
         s2_sign    <= s1_sign;
         s2_exp     <= s1_exp;
         s2_prod    <= PW'(s1_sig_a) * PW'(s1_sig_b);
         out_valid  <= s2_valid;
         out_data   <= res_n;
         out_tag    <= s2_tag;
         out_flags  <= flags_n;
      end
   end

   // a clear coinciding with a handshake keeps that result's flags
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_flags <= '0;
      end else if (out_valid && out_ready) begin
         sticky_flags <= clr_flags ? out_flags : (sticky_flags | out_flags);
      end else if (clr_flags) begin
         sticky_flags <= '0;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: directed BF16 vectors, random back-pressure,
// sticky-flag behaviour, mid-stream reset and an FP16 build.
module tb_fp_mul_pipe;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  t;
      logic [4:0]  f;
      logic [31:0] c;
      logic        lc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, out_valid, out_ready, clr_flags;
   logic [15:0] in_a, in_b, out_data;
   logic [3:0]  in_tag, out_tag;
   logic [4:0]  out_flags, sticky_flags;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_clr;
   logic [15:0] h_in_a, h_in_b, h_out_data;
   logic [3:0]  h_in_tag, h_out_tag;
   logic [4:0]  h_out_flags, h_sticky;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_flags(out_flags),
      .clr_flags(clr_flags), .sticky_flags(sticky_flags));

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
      .out_tag(h_out_tag), .out_flags(h_out_flags),
      .clr_flags(h_clr), .sticky_flags(h_sticky));

   localparam int NV = 14;
   logic [15:0] tv_a [NV] = '{16'h3FC0, 16'h3F81, 16'h3FFF, 16'h7F00, 16'h0080, 16'h7F80, 16'hFF80,
                              16'h7F81, 16'h8000, 16'h0001, 16'hBFC0, 16'h0000, 16'h7F80, 16'h3F80};
   logic [15:0] tv_b [NV] = '{16'h4000, 16'h3FC0, 16'h3FFF, 16'h7F00, 16'h3F00, 16'h0000, 16'h3F80,
                              16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 16'h7F80, 16'hFF80, 16'h3F80};
   logic [15:0] tv_p [NV] = '{16'h4040, 16'h3FC2, 16'h407E, 16'h7F80, 16'h0000, 16'h7FC0, 16'hFF80,
                              16'h7FC0, 16'h8000, 16'h0000, 16'hC040, 16'h7FC0, 16'hFF80, 16'h3F80};
   logic [4:0]  tv_f [NV] = '{5'b00000, 5'b00010, 5'b00010, 5'b01010, 5'b00111, 5'b10000, 5'b00000,
                              5'b10000, 5'b00001, 5'b00001, 5'b00000, 5'b10000, 5'b00000, 5'b00000};

   exp_t        q[$];
   exp_t        hq[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   bit          rnd_mode = 1'b0;
   logic [4:0]  sticky_model;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // main monitor: pops the scoreboard on every handshake
   initial begin : mon
      exp_t        e;
      logic        stalled;
      logic [15:0] hd;
      logic [3:0]  ht;
      logic [4:0]  hf;
      stalled = 1'b0;
      hd = '0; ht = '0; hf = '0;
      sticky_model = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            sticky_model = '0;
            stalled = 1'b0;
            continue;
         end
         check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
         check("sticky_track", 32'(sticky_flags), 32'(sticky_model));
         if (stalled) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(hd));
            check("hold_tag", 32'(out_tag), 32'(ht));
            check("hold_flags", 32'(out_flags), 32'(hf));
         end
         stalled = out_valid && !out_ready;
         if (stalled) {hd, ht, hf} = {out_data, out_tag, out_flags};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got data 0x%0h tag %0d, want none", out_data, out_tag);
            end else begin
               e = q.pop_front();
               check("data", 32'(out_data), 32'(e.d));
               check("tag", 32'(out_tag), 32'(e.t));
               check("flags", 32'(out_flags), 32'(e.f));
               if (e.lc) check("latency", cyc - e.c, 32'd3);
               sticky_model = clr_flags ? e.f : (sticky_model | e.f);
            end
         end else if (clr_flags) begin
            sticky_model = '0;
         end
      end
   end

   // FP16 monitor
   initial begin : mon_h
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && h_out_valid) begin
            if (hq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL h_unexpected_output: got data 0x%0h, want none", h_out_data);
            end else begin
               e = hq.pop_front();
               check("h_data", 32'(h_out_data), 32'(e.d));
               check("h_tag", 32'(h_out_tag), 32'(e.t));
               check("h_flags", 32'(h_out_flags), 32'(e.f));
               check("h_latency", cyc - e.c, 32'd3);
            end
         end
      end
   end

   // called on a falling edge; returns on the falling edge after acceptance
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                       input logic [15:0] d, input logic [4:0] f);
      exp_t        e;
      int unsigned n;
      bit          done;
      n = 0;
      done = 1'b0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_tag = t;
      while (!done) begin
         #1;
         if (in_ready) begin
            e.d = d; e.t = t; e.f = f; e.c = cyc; e.lc = !rnd_mode;
            q.push_back(e);
            done = 1'b1;
         end
         @(negedge clk);
         n++;
         if (!done && n > 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want 1", n);
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                         input logic [15:0] d, input logic [4:0] f);
      exp_t e;
      h_in_valid = 1'b1;
      h_in_a = a;
      h_in_b = b;
      h_in_tag = t;
      #1;
      check("h_in_ready", 32'(h_in_ready), 32'd1);
      e.d = d; e.t = t; e.f = f; e.c = cyc; e.lc = 1'b1;
      hq.push_back(e);
      @(negedge clk);
      h_in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while ((q.size() != 0 || hq.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(q.size() + hq.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin : stim
      int unsigned n;
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; clr_flags = 1'b0;
      h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_tag = '0;
      h_out_ready = 1'b1; h_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      check("rst_sticky", 32'(sticky_flags), 32'd0);
      @(negedge clk);

      // overflow alone, then a plain clear
      send(tv_a[3], tv_b[3], 4'd5, tv_p[3], tv_f[3]);
      drain();
      #3;
      check("sticky_after_ovf", 32'(sticky_flags), 32'b01010);
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      #3;
      check("sticky_after_clr", 32'(sticky_flags), 32'd0);
      @(negedge clk);

      // directed vectors, back-to-back
      for (int i = 0; i < NV; i++) send(tv_a[i], tv_b[i], 4'(i), tv_p[i], tv_f[i]);
      drain();

      // clear on the same handshake as an invalid result
      send(tv_a[5], tv_b[5], 4'd9, tv_p[5], tv_f[5]);
      n = 0;
      #1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("clr_wait_valid", 32'(out_valid), 32'd1);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      #3;
      check("sticky_clr_on_hs", 32'(sticky_flags), 32'b10000);
      @(negedge clk);

      // random back-pressure stream
      rnd_mode = 1'b1;
      for (int i = 0; i < 8; i++) send(tv_a[i], tv_b[i], 4'(8 + i), tv_p[i], tv_f[i]);
      drain();
      rnd_mode = 1'b0;
      repeat (2) @(negedge clk);

      // reset with two operations in flight
      send(tv_a[0], tv_b[0], 4'd1, tv_p[0], tv_f[0]);
      send(tv_a[3], tv_b[3], 4'd2, tv_p[3], tv_f[3]);
      rst = 1'b1;
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("flush_no_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      #3;
      check("flush_sticky", 32'(sticky_flags), 32'd0);
      @(negedge clk);

      // FP16 build
      send_h(16'h3E00, 16'h4000, 4'd6, 16'h4200, 5'b00000);
      send_h(16'h7BFF, 16'h4000, 4'd7, 16'h7C00, 5'b01010);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got no finish by %0t, want finish", $time);
      $fatal(1, "timeout");
   end

endmodule
